ca_flow_monitor: RTL and testbench
==================================

Name: ca_flow_monitor

Overview:
- Downstream consumer of the rule-184 traffic automaton's `state` vector.
- Samples one generation per `in_valid` pulse.
- Computes the following for each generation:
  - Car density (popcount).
  - Per-generation flux (cars that move this step).
  - Windowed flux sum.
  - Status flags (frozen, free flow, conservation violation).
- Feeds the lab's statistics/readout logic.

Parameters:
WIDTH, 20, number of cells in the ring (must match the automaton)
CNT_W, 5, width of density/move counts; 2^CNT_W > WIDTH
WINDOW, 16, generations per flux accumulation window (>=2)
ACC_W, 9, flux accumulator width; 2^ACC_W > WIDTH*WINDOW (no saturation logic)

Ports:
clk  in  1  rising-edge clock
res  in  1  reset; synchronous, active-high
in_valid  in  1  one generation presented on state this cycle
state  in  WIDTH  current automaton generation, bit i = cell i (1 = car)
out_valid  out  1  density/moves/flags valid pulse, 1 cycle
density  out  CNT_W  popcount of last sample
moves  out  CNT_W  cars moving in last sample
frozen  out  1  last sample identical to previous sample
free_flow  out  1  last sample has moves == density and density != 0
cons_err  out  1  sticky: density changed between consecutive samples
flux_sum  out  ACC_W  total moves over last completed window
win_done  out  1  flux_sum updated pulse, 1 cycle

Behaviour:
- Reset (`res`=1 at a posedge):
  - All outputs are 0.
  - Accumulator, window counter, previous-sample register and have_prev flag are cleared.
  - `res` overrides `in_valid` in the same cycle.
  - Reset mid-window discards the partial window; no `win_done`.
- Move rule matches the automaton's neighbourhood ordering:
  - A car at cell i+1 moves into cell i when cell i is empty.
  - moves = count of i in 0..WIDTH-1 with state[(i+1) mod WIDTH]=1 and state[i]=0.
  - The ring wraps: cell 0's upstream neighbour is cell WIDTH-1.
- Latency 1. For a sample accepted at edge N (`in_valid`=1), at edge N+1:
  - density, moves, frozen, free_flow are registered.
  - out_valid=1 for exactly one cycle.
  - When `in_valid` is low, out_valid=0 and data outputs hold their values.
- Previous sample:
  - Stored on every accepted sample; have_prev is set on the first one.
  - For the first sample after reset: frozen=0 and cons_err is not evaluated.
  - For later samples: frozen = (state == prev).
- cons_err:
  - Set when have_prev=1 and popcount(state) != popcount(prev).
  - Remains 1 until `res`.
- Window FSM, states ACCUM and DUMP:
  - ACCUM: each accepted sample adds moves to acc and increments wcnt (0..WINDOW-1).
  - The sample with wcnt==WINDOW-1 triggers DUMP, evaluated in the output cycle:
    - flux_sum <= acc + moves, win_done=1 for 1 cycle, coincident with that sample's out_valid.
    - acc <= 0, wcnt <= 0, return to ACCUM.
  - A sample arriving in the DUMP cycle is accepted normally and counted as the first sample of the new window. Nothing is dropped and there are no bubbles.
  - flux_sum holds between windows.
- Back-to-back `in_valid` every cycle is supported at full rate. Gaps of any length are allowed.

Test Plan:
- Reset, then 3 samples of 20'h00000 -> density=0, moves=0, free_flow=0; frozen=0 on first, 1 on 2nd/3rd; cons_err=0.
- Samples 20'h00001 then 20'h80000 -> each: density=1, moves=1 (wrap 0->19 path), free_flow=1, frozen=0, out_valid 1 cycle after each `in_valid`.
- 20'hFFFFF twice -> density=20, moves=0, free_flow=0, frozen=1 on second.
- 16 back-to-back samples of 20'hAAAAA/20'h55555 alternating -> each moves=10, density=10, free_flow=1; win_done pulses once with flux_sum=160 aligned to the 16th out_valid; 17th sample starts new window (next flux_sum=160 after 16 more).
- Sample 20'habcde (density 13) then 20'h00003 -> cons_err rises with second out_valid and stays 1 through further valid samples until `res`.
- Reset asserted after 7 of 16 window samples (with `in_valid` high in the same cycle) -> all outputs 0 next cycle, no win_done; next window needs a full 16 samples, and the first post-reset sample reports frozen=0.

Source files
------------

// File: rtl/ca_flow_monitor.sv
// Flow statistics for a rule-184 traffic ring: density, per-step moves, status flags
// and a windowed flux sum, one result per accepted generation with 1-cycle latency.
module ca_flow_monitor #(
  parameter int WIDTH  = 20,
  parameter int CNT_W  = 5,
  parameter int WINDOW = 16,
  parameter int ACC_W  = 9
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] state,
  output logic             out_valid,
  output logic [CNT_W-1:0] density,
  output logic [CNT_W-1:0] moves,
  output logic             frozen,
  output logic             free_flow,
  output logic             cons_err,
  output logic [ACC_W-1:0] flux_sum,
  output logic             win_done
);

  localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic {ACCUM, DUMP} win_state_t;

  win_state_t       wstate;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] upstream;
  logic [WIDTH-1:0] moving;
  logic [CNT_W-1:0] prev_pop;
  logic [CNT_W-1:0] pop_now;
  logic [CNT_W-1:0] mv_now;
  logic             have_prev;
  logic [ACC_W-1:0] acc;
  logic [WC_W-1:0]  wcnt;
  logic             last;

  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // upstream[i] is the occupant of cell i+1 (ring wraps); a car moves into an empty cell i.
  always_comb begin
    upstream = {state[0], state[WIDTH-1:1]};
    moving   = upstream & ~state;
    pop_now  = popcnt(state);
    mv_now   = popcnt(moving);
    last     = (wcnt == WC_W'(WINDOW - 1));
    win_done = (wstate == DUMP);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wstate    <= ACCUM;
      prev      <= '0;
      prev_pop  <= '0;
      have_prev <= 1'b0;
      acc       <= '0;
      wcnt      <= '0;
      out_valid <= 1'b0;
      density   <= '0;
      moves     <= '0;
      frozen    <= 1'b0;
      free_flow <= 1'b0;
      cons_err  <= 1'b0;
      flux_sum  <= '0;
    end else begin
      out_valid <= in_valid;
      wstate    <= ACCUM;
      if (in_valid) begin
        density   <= pop_now;
        moves     <= mv_now;
        frozen    <= have_prev && (state == prev);
        free_flow <= (mv_now == pop_now) && (pop_now != '0);
        if (have_prev && (pop_now != prev_pop)) begin
          cons_err <= 1'b1;
        end
        prev      <= state;
        prev_pop  <= pop_now;
        have_prev <= 1'b1;
        // acc/wcnt are already cleared on entering DUMP, so a sample in that cycle
        // simply starts the next window.
        if (last) begin
          flux_sum <= acc + ACC_W'(mv_now);
          acc      <= '0;
          wcnt     <= '0;
          wstate   <= DUMP;
        end else begin
          acc  <= acc + ACC_W'(mv_now);
          wcnt <= wcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ca_flow_monitor.sv
// Scoreboard bench for ca_flow_monitor: a reference model pushes expected results per
// accepted sample; a monitor pops and compares them on every cycle.
module tb_ca_flow_monitor;
  localparam int WIDTH  = 20;
  localparam int CNT_W  = 5;
  localparam int WINDOW = 16;
  localparam int ACC_W  = 9;

  logic             clk = 1'b0;
  logic             res;
  logic             in_valid;
  logic [WIDTH-1:0] state;
  logic             out_valid;
  logic [CNT_W-1:0] density;
  logic [CNT_W-1:0] moves;
  logic             frozen;
  logic             free_flow;
  logic             cons_err;
  logic [ACC_W-1:0] flux_sum;
  logic             win_done;

  always #5 clk = ~clk;

  ca_flow_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WINDOW(WINDOW), .ACC_W(ACC_W)) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .state(state),
    .out_valid(out_valid), .density(density), .moves(moves), .frozen(frozen),
    .free_flow(free_flow), .cons_err(cons_err), .flux_sum(flux_sum), .win_done(win_done)
  );

  typedef struct packed {
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] m;
    logic             fr;
    logic             ff;
    logic             ce;
    logic [ACC_W-1:0] flux;
    logic             win;
  } exp_t;

  exp_t q[$];
  exp_t held;
  exp_t mon_obs;
  exp_t mon_exp;
  int   vectors = 0;
  int   miscompares = 0;
  int   wins = 0;
  bit   mon_en = 1'b0;
  bit   mon_ov;

  logic [WIDTH-1:0] m_prev;
  bit               m_have;
  bit               m_cons;
  int               m_acc;
  int               m_wcnt;
  logic [ACC_W-1:0] m_flux;

  function automatic int ref_pop(input logic [WIDTH-1:0] s);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) if (s[i]) n++;
    return n;
  endfunction

  function automatic int ref_moves(input logic [WIDTH-1:0] s);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) if (s[(i + 1) % WIDTH] && !s[i]) n++;
    return n;
  endfunction

  // One clock of stimulus; the model advances as the inputs are driven.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] s, input logic r);
    exp_t e;
    int d;
    int mv;
    @(negedge clk);
    res = r; in_valid = v; state = s;
    if (r) begin
      m_have = 0; m_cons = 0; m_acc = 0; m_wcnt = 0; m_flux = '0; m_prev = '0;
      held = '0;
    end else if (v) begin
      d  = ref_pop(s);
      mv = ref_moves(s);
      e.d  = CNT_W'(d);
      e.m  = CNT_W'(mv);
      e.fr = m_have && (s == m_prev);
      e.ff = (mv == d) && (d != 0);
      if (m_have && (d != ref_pop(m_prev))) m_cons = 1;
      e.ce = m_cons;
      if (m_wcnt == WINDOW - 1) begin
        m_flux = ACC_W'(m_acc + mv);
        m_acc = 0; m_wcnt = 0; e.win = 1'b1;
      end else begin
        m_acc += mv; m_wcnt++; e.win = 1'b0;
      end
      e.flux = m_flux;
      m_prev = s; m_have = 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, WIDTH'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b1);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      mon_obs = {density, moves, frozen, free_flow, cons_err, flux_sum, win_done};
      mon_ov  = (q.size() != 0);
      if (win_done === 1'b1) wins++;
      vectors++;
      if (out_valid !== mon_ov) begin
        miscompares++;
        $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, mon_ov);
      end
      if (mon_ov) begin
        mon_exp = q.pop_front();
        held = mon_exp;
        held.win = 1'b0;
      end else begin
        mon_exp = held;
      end
      vectors++;
      if (mon_obs !== mon_exp) begin
        miscompares++;
        $display("FAIL outputs t=%0t got d=%0d m=%0d fr=%b ff=%b ce=%b flux=%0d win=%b exp d=%0d m=%0d fr=%b ff=%b ce=%b flux=%0d win=%b",
                 $time, mon_obs.d, mon_obs.m, mon_obs.fr, mon_obs.ff, mon_obs.ce, mon_obs.flux, mon_obs.win,
                 mon_exp.d, mon_exp.m, mon_exp.fr, mon_exp.ff, mon_exp.ce, mon_exp.flux, mon_exp.win);
      end
    end
  end

  task automatic drain();
    idle(2);
    for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d exp=0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 20'hFFFFF, 1'b1);
    cycle(1'b1, 20'h12345, 1'b1);
    @(posedge clk); #2;
    vectors++;
    if ({out_valid, density, moves, frozen, free_flow, cons_err, flux_sum, win_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got ov=%b d=%0d m=%0d fr=%b ff=%b ce=%b flux=%0d win=%b exp all 0",
               out_valid, density, moves, frozen, free_flow, cons_err, flux_sum, win_done);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_empty();
    do_reset();
    repeat (3) cycle(1'b1, 20'h00000, 1'b0);
    drain();
    vectors++;
    if (cons_err !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_cons got=%b exp=0", cons_err);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b1, 20'h00001, 1'b0);
    idle(1);
    cycle(1'b1, 20'h80000, 1'b0);
    @(posedge clk); #2;
    vectors++;
    if ({density, moves, free_flow} !== {5'd1, 5'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap got d=%0d m=%0d ff=%b exp d=1 m=1 ff=1", density, moves, free_flow);
    end
    drain();
  endtask

  task automatic test_full();
    do_reset();
    cycle(1'b1, 20'hFFFFF, 1'b0);
    cycle(1'b1, 20'hFFFFF, 1'b0);
    @(posedge clk); #2;
    vectors++;
    if ({density, moves, frozen, free_flow} !== {5'd20, 5'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL full got d=%0d m=%0d fr=%b ff=%b exp d=20 m=0 fr=1 ff=0", density, moves, frozen, free_flow);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int w0;
    do_reset();
    w0 = wins;
    for (int i = 0; i < 2 * WINDOW; i++) cycle(1'b1, (i % 2) ? 20'h55555 : 20'hAAAAA, 1'b0);
    drain();
    vectors++;
    if ((wins - w0) != 2 || flux_sum !== 9'd160) begin
      miscompares++;
      $display("FAIL back_to_back got wins=%0d flux=%0d exp wins=2 flux=160", wins - w0, flux_sum);
    end
  endtask

  task automatic test_cons();
    do_reset();
    cycle(1'b1, 20'habcde, 1'b0);
    cycle(1'b1, 20'h00003, 1'b0);
    idle(1);
    repeat (3) cycle(1'b1, 20'h00003, 1'b0);
    drain();
    vectors++;
    if (cons_err !== 1'b1) begin
      miscompares++;
      $display("FAIL cons_sticky got=%b exp=1", cons_err);
    end
    do_reset();
    @(posedge clk); #2;
    vectors++;
    if (cons_err !== 1'b0) begin
      miscompares++;
      $display("FAIL cons_clear got=%b exp=0", cons_err);
    end
  endtask

  task automatic test_mid_reset();
    int w0;
    do_reset();
    w0 = wins;
    repeat (7) cycle(1'b1, 20'h0F0F0, 1'b0);
    cycle(1'b1, 20'h0F0F0, 1'b1);
    @(posedge clk); #2;
    vectors++;
    if ({out_valid, density, moves, frozen, free_flow, cons_err, flux_sum, win_done} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got ov=%b d=%0d m=%0d flux=%0d win=%b exp all 0",
               out_valid, density, moves, flux_sum, win_done);
    end
    repeat (WINDOW - 1) cycle(1'b1, 20'h0F0F0, 1'b0);
    drain();
    vectors++;
    if (wins != w0) begin
      miscompares++;
      $display("FAIL mid_reset_early_win got=%0d exp=%0d", wins, w0);
    end
    cycle(1'b1, 20'h0F0F0, 1'b0);
    drain();
    vectors++;
    if ((wins - w0) != 1 || flux_sum !== 9'd32) begin
      miscompares++;
      $display("FAIL mid_reset_window got wins=%0d flux=%0d exp wins=1 flux=32", wins - w0, flux_sum);
    end
  endtask

  task automatic test_gaps();
    logic [WIDTH-1:0] s;
    do_reset();
    s = WIDTH'($urandom);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) s = WIDTH'($urandom);
      cycle(1'b1, s, 1'b0);
      idle($urandom_range(0, 2));
    end
    drain();
  endtask

  initial begin
    res = 1'b1; in_valid = 1'b0; state = '0; held = '0;
    m_prev = '0; m_have = 0; m_cons = 0; m_acc = 0; m_wcnt = 0; m_flux = '0;
    test_reset();
    test_empty();
    test_wrap();
    test_full();
    test_back_to_back();
    test_cons();
    test_mid_reset();
    test_gaps();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
